db_cmd_decoder: RTL and testbench

DB_CMD_DECODER -- requirements
Module: db_cmd_decoder

---
 rtl/db_pkg.sv | 57 +++++
 rtl/db_byte_shifter.sv | 37 +++
 rtl/db_cmd_decoder.sv | 154 +++++++++++++++
 tb/tb_db_cmd_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// rtl/db_pkg.sv - opcode, reply and FSM state definitions for the command decoder
package db_pkg;

    localparam logic [7:0] OP_PAUSE  = 8'h01;
    localparam logic [7:0] OP_RESUME = 8'h02;
    localparam logic [7:0] OP_MEM_RD = 8'h03;
    localparam logic [7:0] OP_MEM_WR = 8'h04;
    localparam logic [7:0] OP_REG_RD = 8'h05;
    localparam logic [7:0] OP_REG_WR = 8'h06;
    localparam logic [7:0] OP_RESET  = 8'h07;

    localparam logic [7:0] RSP_ACK = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op >= OP_PAUSE) && (op <= OP_RESET);
    endfunction

    function automatic logic op_has_args(input logic [7:0] op);
        return (op == OP_MEM_RD) || (op == OP_MEM_WR) ||
               (op == OP_REG_RD) || (op == OP_REG_WR);
    endfunction

    function automatic logic op_has_data(input logic [7:0] op);
        return (op == OP_MEM_WR) || (op == OP_REG_WR);
    endfunction

    function automatic logic op_is_read(input logic [7:0] op);
        return (op == OP_MEM_RD) || (op == OP_REG_RD);
    endfunction

    // Bit order: pause, resume, mem_rd, mem_wr, reg_rd, reg_wr, reset
    function automatic logic [6:0] op_strobe(input logic [7:0] op);
        logic [6:0] s;
        s = 7'h00;
        case (op)
            OP_PAUSE:  s = 7'b000_0001;
            OP_RESUME: s = 7'b000_0010;
            OP_MEM_RD: s = 7'b000_0100;
            OP_MEM_WR: s = 7'b000_1000;
            OP_REG_RD: s = 7'b001_0000;
            OP_REG_WR: s = 7'b010_0000;
            OP_RESET:  s = 7'b100_0000;
            default:   s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/db_byte_shifter.sv
// rtl/db_byte_shifter.sv - serialises a 1- or 4-byte reply MSB-first under a valid/ready handshake
module db_byte_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        wide,
    input  logic [31:0] data,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);

    logic [31:0] sreg;
    logic [2:0]  remaining;

    assign tx_data = sreg[31:24];
    assign done    = tx_valid && tx_ready && (remaining == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= 32'h0;
            remaining <= 3'd0;
            tx_valid  <= 1'b0;
        end else if (load) begin
            sreg      <= wide ? data : {data[7:0], 24'h0};
            remaining <= wide ? 3'd4 : 3'd1;
            tx_valid  <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            sreg      <= {sreg[23:0], 8'h0};
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1)
                tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/db_cmd_decoder.sv
// rtl/db_cmd_decoder.sv - serial command frame decoder issuing one-hot MCU strobes and a byte reply
module db_cmd_decoder
    import db_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        pause,
    output logic        resume,
    output logic        reset,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic        valid,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    input  logic [31:0] d_rd,
    input  logic        mcu_busy,
    output logic        rx_overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [7:0]    opcode;
    logic [2:0]    byte_cnt;
    logic [2:0]    last_idx;
    logic [TW-1:0] timer;
    logic [6:0]    strb;

    logic          sh_load;
    logic          sh_wide;
    logic [31:0]   sh_data;
    logic          sh_done;

    assign pause  = strb[0];
    assign resume = strb[1];
    assign mem_rd = strb[2];
    assign mem_wr = strb[3];
    assign reg_rd = strb[4];
    assign reg_wr = strb[5];
    assign reset  = strb[6];

    assign last_idx = op_has_data(opcode) ? 3'd7 : 3'd3;

    // The reply is loaded on the same edge the FSM enters RESP, so tx_valid is up for the whole of RESP
    always_comb begin
        sh_load = 1'b0;
        sh_wide = 1'b0;
        sh_data = {24'h0, RSP_ACK};
        if (state == ST_IDLE && rx_valid && !op_known(rx_data)) begin
            sh_load = 1'b1;
            sh_data = {24'h0, RSP_ERR};
        end else if (state == ST_WAIT && !mcu_busy) begin
            sh_load = 1'b1;
            if (op_is_read(opcode)) begin
                sh_wide = 1'b1;
                sh_data = d_rd;
            end
        end
    end

    db_byte_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .wide     (sh_wide),
        .data     (sh_data),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (sh_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            opcode     <= 8'h00;
            byte_cnt   <= 3'd0;
            timer      <= '0;
            strb       <= 7'h00;
            valid      <= 1'b0;
            addr       <= 32'h0;
            d_in       <= 32'h0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_valid &&
                          (state == ST_ISSUE || state == ST_WAIT || state == ST_RESP);
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (op_known(rx_data)) begin
                            opcode   <= rx_data;
                            byte_cnt <= 3'd0;
                            timer    <= '0;
                            if (op_has_args(rx_data)) begin
                                state <= ST_ARGS;
                            end else begin
                                state <= ST_ISSUE;
                                valid <= 1'b1;
                                strb  <= op_strobe(rx_data);
                            end
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ARGS: begin
                    if (rx_valid) begin
                        timer <= '0;
                        if (byte_cnt[2])
                            d_in <= {d_in[23:0], rx_data};
                        else
                            addr <= {addr[23:0], rx_data};
                        if (byte_cnt == last_idx) begin
                            state <= ST_ISSUE;
                            valid <= 1'b1;
                            strb  <= op_strobe(opcode);
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    valid <= 1'b0;
                    strb  <= 7'h00;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!mcu_busy)
                        state <= ST_RESP;
                end
                ST_RESP: begin
                    if (sh_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_db_cmd_decoder.sv
// tb/tb_db_cmd_decoder.sv - directed self-checking bench for db_cmd_decoder
module tb_db_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        pause, resume, reset, mem_rd, mem_wr, reg_rd, reg_wr;
    logic        valid;
    logic [31:0] addr, d_in;
    logic [31:0] d_rd = 32'h0;
    logic        mcu_busy = 1'b0;
    logic        rx_overrun;

    int tests = 0;
    int fails = 0;

    int          nvalid = 0;
    int          novr = 0;
    int          bad = 0;
    int          stall = 0;
    int          stall_cnt = 0;
    logic        held = 1'b0;
    logic [7:0]  held_data = 8'h00;
    logic [6:0]  last_vec = 7'h0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_din = 32'h0;
    logic [7:0]  txq[$];
    logic [6:0]  vec;

    assign vec = {reset, reg_wr, reg_rd, mem_wr, mem_rd, resume, pause};

    always #5 clk = ~clk;

    db_cmd_decoder #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pause(pause), .resume(resume), .reset(reset), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .reg_rd(reg_rd), .reg_wr(reg_wr), .valid(valid),
        .addr(addr), .d_in(d_in), .d_rd(d_rd), .mcu_busy(mcu_busy),
        .rx_overrun(rx_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Observes strobes/overrun and plays the transmitter, stalling each byte `stall` cycles
    initial forever begin
        @(negedge clk);
        if (valid) begin
            nvalid++;
            last_vec  = vec;
            last_addr = addr;
            last_din  = d_in;
            if (!$onehot(vec)) bad++;
        end else if (vec != 7'h0) begin
            bad++;
        end
        if (rx_overrun) novr++;
        if (tx_valid) begin
            if (stall_cnt >= stall) begin
                tx_ready = 1'b1;
                txq.push_back(tx_data);
                stall_cnt = 0;
                held = 1'b0;
            end else begin
                tx_ready = 1'b0;
                stall_cnt++;
                if (held) chk("tx_data_stable", {24'h0, tx_data}, {24'h0, held_data});
                held = 1'b1;
                held_data = tx_data;
            end
        end else begin
            tx_ready = 1'b0;
            stall_cnt = 0;
            held = 1'b0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int k = 0;
        while (txq.size() < n && k < 400) begin
            step();
            k++;
        end
        chk(tag, {31'h0, k < 400}, 32'h1);
        step(2);
    endtask

    task automatic clear();
        nvalid = 0;
        novr = 0;
        last_vec = 7'h0;
        last_addr = 32'h0;
        last_din = 32'h0;
        txq.delete();
    endtask

    initial begin
        step(2);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_strobes", {25'h0, vec}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_overrun", {31'h0, rx_overrun}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_d_in", d_in, 32'h0);
        rst_n = 1'b1;
        step(2);

        // mem_wr with busy held for 3 cycles after ISSUE
        clear();
        mcu_busy = 1'b1;
        stall = 0;
        send(8'h04); send(8'h00); send(8'h00); send(8'h00); send(8'h10);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        chk("wr_valid_pulse", nvalid, 1);
        step(3);
        chk("wr_no_tx_while_busy", {31'h0, tx_valid}, 32'h0);
        chk("wr_txq_empty_busy", txq.size(), 0);
        mcu_busy = 1'b0;
        wait_tx("wr_tx_timeout", 1);
        chk("wr_strobe", {25'h0, last_vec}, 32'h08);
        chk("wr_addr", last_addr, 32'h10);
        chk("wr_d_in", last_din, 32'hDEADBEEF);
        chk("wr_reply", {24'h0, txq[0]}, 32'hA5);
        chk("wr_valid_count", nvalid, 1);

        // reg_rd with 2 stall cycles per byte
        clear();
        stall = 2;
        d_rd = 32'h12345678;
        send(8'h05); send(8'h00); send(8'h00); send(8'h00); send(8'h07);
        wait_tx("rd_tx_timeout", 4);
        chk("rd_valid_count", nvalid, 1);
        chk("rd_strobe", {25'h0, last_vec}, 32'h10);
        chk("rd_addr", last_addr, 32'h7);
        chk("rd_byte_count", txq.size(), 4);
        chk("rd_byte0", {24'h0, txq[0]}, 32'h12);
        chk("rd_byte1", {24'h0, txq[1]}, 32'h34);
        chk("rd_byte2", {24'h0, txq[2]}, 32'h56);
        chk("rd_byte3", {24'h0, txq[3]}, 32'h78);

        // pause then resume, no arguments
        clear();
        stall = 0;
        send(8'h01);
        wait_tx("pause_tx_timeout", 1);
        chk("pause_strobe", {25'h0, last_vec}, 32'h01);
        chk("pause_reply", {24'h0, txq[0]}, 32'hA5);
        chk("pause_valid_count", nvalid, 1);
        clear();
        send(8'h02);
        wait_tx("resume_tx_timeout", 1);
        chk("resume_strobe", {25'h0, last_vec}, 32'h02);
        chk("resume_reply", {24'h0, txq[0]}, 32'hA5);
        chk("resume_valid_count", nvalid, 1);

        // partial frame abandoned by the inter-byte timeout
        clear();
        send(8'h03); send(8'h00); send(8'h00);
        step(30);
        chk("to_no_strobe", nvalid, 0);
        chk("to_no_tx", txq.size(), 0);
        chk("to_tx_valid", {31'h0, tx_valid}, 32'h0);
        send(8'h01);
        wait_tx("to_pause_tx_timeout", 1);
        chk("to_pause_strobe", {25'h0, last_vec}, 32'h01);
        chk("to_pause_reply", {24'h0, txq[0]}, 32'hA5);

        // timer restarts on each byte: 15-cycle gaps sum past the timeout
        clear();
        d_rd = 32'hCAFEF00D;
        send(8'h03); send(8'hAA); step(15); send(8'hBB); step(15);
        send(8'hCC); step(15); send(8'hDD);
        wait_tx("gap_tx_timeout", 4);
        chk("gap_strobe", {25'h0, last_vec}, 32'h04);
        chk("gap_addr", last_addr, 32'hAABBCCDD);
        chk("gap_byte0", {24'h0, txq[0]}, 32'hCA);
        chk("gap_byte3", {24'h0, txq[3]}, 32'h0D);

        // unknown opcode and an overrun during RESP
        clear();
        stall = 3;
        send(8'h42);
        step(1);
        send(8'h55);
        wait_tx("bad_tx_timeout", 1);
        chk("bad_reply", {24'h0, txq[0]}, 32'hEE);
        chk("bad_no_strobe", nvalid, 0);
        chk("bad_overrun_once", novr, 1);
        chk("bad_tx_count", txq.size(), 1);

        // reset in the middle of a 4-byte reply
        clear();
        stall = 3;
        d_rd = 32'h11223344;
        send(8'h05); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        begin
            int k = 0;
            while (txq.size() < 1 && k < 200) begin
                step();
                k++;
            end
            chk("mid_first_byte_timeout", {31'h0, k < 200}, 32'h1);
        end
        step(1);
        chk("mid_first_byte", {24'h0, txq[0]}, 32'h11);
        chk("mid_tx_valid_before", {31'h0, tx_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_tx_valid_reset", {31'h0, tx_valid}, 32'h0);
        chk("mid_addr_reset", addr, 32'h0);
        step(1);
        rst_n = 1'b1;
        step(1);
        clear();
        stall = 0;
        send(8'h01);
        wait_tx("post_rst_tx_timeout", 1);
        chk("post_rst_strobe", {25'h0, last_vec}, 32'h01);
        chk("post_rst_reply", {24'h0, txq[0]}, 32'hA5);
        chk("post_rst_tx_count", txq.size(), 1);

        chk("strobe_onehot_violations", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
